tag_pattern_gen: RTL and testbench



---
 rtl/tag_pattern_gen.sv | 100 ++++++++++
 tb/tb_tag_pattern_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_pattern_gen.sv
// Synthetic tag source: bursts of tags with monotonic timestamps and LFSR-driven channel/edge.
// Define TAG_PATTERN_GEN_RANDOM_VALID_EN to gate emission on lfsr[0] (random gaps, ~50 % duty).
`timescale 1ns/1ps
module tag_pattern_gen #(
    parameter int          CHANNELS  = 3,
    parameter logic [31:0] EVENT_GAP = 32'd4000,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] burst_len,
    output logic        busy,
    output logic        done,
    output logic [31:0] tag_count,
    output logic        valid_tag,
    output logic [63:0] tagtime,
    output logic [4:0]  channel,
    output logic        rising_edge
);

    localparam logic [31:0] TAP_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] lfsr;
    logic [31:0] latched_len;
    logic        emit;
    logic        fire;
    logic        last_tag;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAP_MASK) : (s >> 1);
    endfunction

    function automatic logic [4:0] chan_of(input logic [31:0] s);
        logic [31:0] v;
        v = 32'(s[12:8]) % 32'(CHANNELS);
        return v[4:0];
    endfunction

    always_comb begin
`ifdef TAG_PATTERN_GEN_RANDOM_VALID_EN
        emit = lfsr[0];
`else
        emit = 1'b1;
`endif
        // stop pre-empts emission in the same cycle
        fire     = (state == RUN) && !stop && emit;
        last_tag = fire && (latched_len != 32'd0) && ((tag_count + 32'd1) == latched_len);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop || last_tag) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr        <= LFSR_SEED;
            latched_len <= 32'd0;
            tag_count   <= 32'd0;
            valid_tag   <= 1'b0;
            tagtime     <= 64'd0;
            channel     <= 5'd0;
            rising_edge <= 1'b0;
        end else begin
            valid_tag <= fire;
            if (state == IDLE && start) begin
                latched_len <= burst_len;
                tag_count   <= 32'd0;
            end
            if (state == RUN)
                lfsr <= lfsr_next(lfsr);
            // tagtime is deliberately never cleared between bursts
            if (fire) begin
                tagtime     <= tagtime + 64'(EVENT_GAP);
                channel     <= chan_of(lfsr);
                rising_edge <= lfsr[16];
                tag_count   <= tag_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_tag_pattern_gen.sv
// Directed bench for tag_pattern_gen (default parameters); covers both builds of TAG_PATTERN_GEN_RANDOM_VALID_EN.
`timescale 1ns/1ps
module tb_tag_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] burst_len = 32'd0;
    logic        busy, done, valid_tag, rising_edge;
    logic [31:0] tag_count;
    logic [63:0] tagtime;
    logic [4:0]  channel;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_lfsr;
    logic [4:0]  exp_ch;
    logic        exp_re;

    tag_pattern_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
        .busy(busy), .done(done), .tag_count(tag_count), .valid_tag(valid_tag),
        .tagtime(tagtime), .channel(channel), .rising_edge(rising_edge)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference LFSR: advances on every edge taken while the DUT is in RUN
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_lfsr <= 32'hACE1_2468;
            exp_ch     <= 5'd0;
            exp_re     <= 1'b0;
        end else if (busy) begin
            exp_ch     <= 5'(model_lfsr[12:8] % 3);
            exp_re     <= model_lfsr[16];
            model_lfsr <= ref_step(model_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] len);
        burst_len = len;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (valid_tag) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic        ok;
        int          n, cyc, ch_bad, gap_bad;
        int          seen0, seen1, seen2, re0, re1;
        logic [63:0] prev;

        // Reset values
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(valid_tag), 64'd0);
        chk("rst_tagtime", tagtime, 64'd0);
        chk("rst_count", 64'(tag_count), 64'd0);
        chk("rst_channel", 64'(channel), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

`ifndef TAG_PATTERN_GEN_RANDOM_VALID_EN
        // Burst of 5 from reset
        pulse_start(32'd5);
        chk("b1_busy_after_start", 64'(busy), 64'd1);
        chk("b1_valid_after_start", 64'(valid_tag), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("b1_valid", 64'(valid_tag), 64'd1);
            chk("b1_tagtime", tagtime, 64'(4000 * i));
            chk("b1_count", 64'(tag_count), 64'(i));
            chk("b1_chan_model", 64'(channel), 64'(exp_ch));
            chk("b1_edge_model", 64'(rising_edge), 64'(exp_re));
            chk("b1_busy", 64'(busy), (i == 5) ? 64'd0 : 64'd1);
            chk("b1_done", 64'(done), (i == 5) ? 64'd1 : 64'd0);
            if (i == 1) begin
                chk("b1_first_chan", 64'(channel), 64'd1);
                chk("b1_first_edge", 64'(rising_edge), 64'd1);
            end
        end
        step();
        chk("b1_done_clear", 64'(done), 64'd0);
        chk("b1_idle_busy", 64'(busy), 64'd0);
        chk("b1_idle_valid", 64'(valid_tag), 64'd0);
        chk("b1_final_count", 64'(tag_count), 64'd5);

        // Back-to-back burst of 2
        pulse_start(32'd2);
        chk("b2_count_cleared", 64'(tag_count), 64'd0);
        step();
        chk("b2_t1", tagtime, 64'd24000);
        chk("b2_c1", 64'(tag_count), 64'd1);
        step();
        chk("b2_t2", tagtime, 64'd28000);
        chk("b2_c2", 64'(tag_count), 64'd2);
        chk("b2_done", 64'(done), 64'd1);
        step();

        // Continuous with a mid-run start (ignored) and a stop after 3 tags
        pulse_start(32'd0);
        step();
        chk("s_t1", tagtime, 64'd32000);
        start = 1'b1;
        burst_len = 32'd2;
        step();
        start = 1'b0;
        chk("s_c2_no_clear", 64'(tag_count), 64'd2);
        chk("s_t2", tagtime, 64'd36000);
        chk("s_busy2_no_relatch", 64'(busy), 64'd1);
        step();
        chk("s_c3", 64'(tag_count), 64'd3);
        chk("s_t3", tagtime, 64'd40000);
        chk("s_busy3", 64'(busy), 64'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s_stop_valid", 64'(valid_tag), 64'd0);
        chk("s_stop_done", 64'(done), 64'd1);
        chk("s_stop_count", 64'(tag_count), 64'd3);
        chk("s_stop_tagtime", tagtime, 64'd40000);
        step();
        chk("s_done_clear", 64'(done), 64'd0);
        chk("s_idle", 64'(busy), 64'd0);
        // stop in IDLE is ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle_stop_ignored", 64'(done), 64'd0);
`else
        // Random-valid build: 1000-tag burst, duty and timestamp spacing
        prev = tagtime;
        pulse_start(32'd1000);
        n = 0; cyc = 0; gap_bad = 0; ch_bad = 0;
        while (cyc < 5000) begin
            step();
            cyc++;
            if (valid_tag) begin
                n++;
                if (tagtime != prev + 64'd4000) gap_bad++;
                if (channel != exp_ch || rising_edge != exp_re) ch_bad++;
                prev = tagtime;
            end
            if (done) break;
        end
        chk("r_done_seen", 64'(done), 64'd1);
        chk("r_tags", 64'(n), 64'd1000);
        chk("r_count", 64'(tag_count), 64'd1000);
        chk("r_gap_errors", 64'(gap_bad), 64'd0);
        chk("r_chan_errors", 64'(ch_bad), 64'd0);
        chk("r_duty_lo", 64'(n * 100 >= cyc * 40), 64'd1);
        chk("r_duty_hi", 64'(n * 100 <= cyc * 60), 64'd1);
        step();
`endif

        // Start and stop together in IDLE: start wins; then 10000 continuous tags
        burst_len = 32'd0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_start_wins", 64'(busy), 64'd1);
        n = 0; cyc = 0; ch_bad = 0;
        seen0 = 0; seen1 = 0; seen2 = 0; re0 = 0; re1 = 0;
        while (n < 10000 && cyc < 40000) begin
            step();
            cyc++;
            if (valid_tag) begin
                n++;
                if (channel >= 5'd3 || channel != exp_ch || rising_edge != exp_re) ch_bad++;
                if (channel == 5'd0) seen0++;
                if (channel == 5'd1) seen1++;
                if (channel == 5'd2) seen2++;
                if (rising_edge) re1++; else re0++;
            end
        end
        chk("c_tags", 64'(n), 64'd10000);
        chk("c_chan_errors", 64'(ch_bad), 64'd0);
        chk("c_seen0", 64'(seen0 > 0), 64'd1);
        chk("c_seen1", 64'(seen1 > 0), 64'd1);
        chk("c_seen2", 64'(seen2 > 0), 64'd1);
        chk("c_edge0", 64'(re0 > 0), 64'd1);
        chk("c_edge1", 64'(re1 > 0), 64'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("c_stop_count", 64'(tag_count), 64'd10000);
        chk("c_stop_done", 64'(done), 64'd1);
        step();

        // Asynchronous reset mid-burst after 2 tags
        pulse_start(32'd10);
        wait_valid(ok);
        chk("ar_tag1_seen", 64'(ok), 64'd1);
        wait_valid(ok);
        chk("ar_tag2_seen", 64'(ok), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_valid", 64'(valid_tag), 64'd0);
        chk("ar_tagtime", tagtime, 64'd0);
        chk("ar_count", 64'(tag_count), 64'd0);
        chk("ar_channel", 64'(channel), 64'd0);
        chk("ar_edge", 64'(rising_edge), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("ar_idle", 64'(busy), 64'd0);
        pulse_start(32'd1);
        wait_valid(ok);
        chk("ar_next_seen", 64'(ok), 64'd1);
        chk("ar_next_tagtime", tagtime, 64'd4000);
        chk("ar_next_count", 64'(tag_count), 64'd1);
        chk("ar_next_chan_model", 64'(channel), 64'(exp_ch));
        chk("ar_next_done", 64'(done), 64'd1);
`ifndef TAG_PATTERN_GEN_RANDOM_VALID_EN
        chk("ar_reseed_chan", 64'(channel), 64'd1);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
